// File: rtl/fft_frame_reader_if.sv
// Stream bundle between the FFT output, the frame reader and its downstream sink.
// The slave modport is the reader's view; the master modport is the driver/sink side.
interface fft_frame_reader_if #(
  parameter int OWIDTH  = 21,
  parameter int LGWIDTH = 11
);
  logic                  i_ce;
  logic [2*OWIDTH-1:0]   i_result;
  logic                  i_sync;
  logic                  i_clear;
  logic                  i_ready;
  logic                  o_valid;
  logic [2*OWIDTH-1:0]   o_data;
  logic [LGWIDTH-1:0]    o_index;
  logic                  o_last;
  logic                  o_overflow;
  logic                  o_syncerr;

  modport slave (
    input  i_ce, i_result, i_sync, i_clear, i_ready,
    output o_valid, o_data, o_index, o_last, o_overflow, o_syncerr
  );

  modport master (
    output i_ce, i_result, i_sync, i_clear, i_ready,
    input  o_valid, o_data, o_index, o_last, o_overflow, o_syncerr
  );
endinterface

// File: rtl/fft_frame_reader.sv
// Captures sync-delimited FFT frames into a ping-pong buffer and replays them on a
// valid/ready stream. Define FFTREADER_SYNCCHK_EN to restart a frame on a mid-frame sync.
module fft_frame_reader #(
  parameter int OWIDTH  = 21,
  parameter int LGWIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  fft_frame_reader_if.slave     bus
);
  localparam int N  = 1 << LGWIDTH;
  localparam int DW = 2 * OWIDTH;
  localparam logic [LGWIDTH-1:0] LAST_IDX = LGWIDTH'(N - 1);
  localparam logic [LGWIDTH-1:0] ONE_IDX  = LGWIDTH'(1);

  typedef enum logic {W_HUNT, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_RUN}  rstate_t;

  logic [DW-1:0] mem [0:2*N-1];

  // write side
  wstate_t              wstate_q, wstate_d;
  logic                 wbank_q, wbank_d;
  logic [LGWIDTH-1:0]   waddr_q, waddr_d;
  logic                 we;
  logic [LGWIDTH-1:0]   we_addr;
  logic                 full_set, ovf_set, serr_set, sync_restart;

  // shared bank ownership
  logic [1:0]           full_q, full_d;
  logic                 full_clr;

  // read side: fetch stage (RAM output) then output register
  rstate_t              rstate_q, rstate_d;
  logic                 rbank_q, rbank_d;
  logic [LGWIDTH-1:0]   raddr_q, raddr_d;
  logic                 rdone_q, rdone_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [LGWIDTH-1:0]   s1_idx_q, s1_idx_d;
  logic                 rd_en, adv;
  logic [DW-1:0]        rdata_q;

  logic                 ovld_q, ovld_d;
  logic [DW-1:0]        odata_q, odata_d;
  logic [LGWIDTH-1:0]   oidx_q, oidx_d;
  logic                 olast_q, olast_d;
  logic                 ovf_q, ovf_d;

`ifdef FFTREADER_SYNCCHK_EN
  logic                 serr_q, serr_d;
  assign sync_restart = bus.i_sync && (waddr_q != '0);
`else
  assign sync_restart = 1'b0;
`endif

  always_comb begin
    wstate_d = wstate_q;
    wbank_d  = wbank_q;
    waddr_d  = waddr_q;
    we       = 1'b0;
    we_addr  = waddr_q;
    full_set = 1'b0;
    ovf_set  = 1'b0;
    serr_set = 1'b0;
    case (wstate_q)
      W_HUNT: begin
        if (bus.i_ce && bus.i_sync) begin
          if (!full_q[wbank_q]) begin
            we       = 1'b1;
            we_addr  = '0;
            waddr_d  = ONE_IDX;
            wstate_d = W_FILL;
          end else begin
            ovf_set  = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (bus.i_ce) begin
          we = 1'b1;
          if (sync_restart) begin
            // the partial frame is abandoned in place; the new sync sample becomes index 0
            serr_set = 1'b1;
            we_addr  = '0;
            waddr_d  = ONE_IDX;
          end else begin
            waddr_d = waddr_q + 1'b1;
            if (waddr_q == LAST_IDX) begin
              full_set = 1'b1;
              wbank_d  = ~wbank_q;
              wstate_d = W_HUNT;
            end
          end
        end
      end
      default: wstate_d = W_HUNT;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rbank_d  = rbank_q;
    raddr_d  = raddr_q;
    rdone_d  = rdone_q;
    s1_vld_d = s1_vld_q;
    s1_idx_d = s1_idx_q;
    rd_en    = 1'b0;
    full_clr = 1'b0;
    ovld_d   = ovld_q;
    odata_d  = odata_q;
    oidx_d   = oidx_q;
    olast_d  = olast_q;
    // fetch and output advance together so the read address never outruns the output
    adv      = !ovld_q || bus.i_ready;
    case (rstate_q)
      R_IDLE: begin
        if (full_q[rbank_q]) begin
          rd_en    = 1'b1;
          s1_vld_d = 1'b1;
          s1_idx_d = '0;
          raddr_d  = ONE_IDX;
          rdone_d  = 1'b0;
          rstate_d = R_RUN;
        end
      end
      R_RUN: begin
        if (adv) begin
          ovld_d = s1_vld_q;
          if (s1_vld_q) begin
            odata_d = rdata_q;
            oidx_d  = s1_idx_q;
            olast_d = (s1_idx_q == LAST_IDX);
          end
          s1_vld_d = !rdone_q;
          if (!rdone_q) begin
            rd_en    = 1'b1;
            s1_idx_d = raddr_q;
            raddr_d  = raddr_q + 1'b1;
            rdone_d  = (raddr_q == LAST_IDX);
          end
        end
        if (ovld_q && bus.i_ready && olast_q) begin
          full_clr = 1'b1;
          rbank_d  = ~rbank_q;
          raddr_d  = '0;
          rdone_d  = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // writer only sets, reader only clears; they never target the same bank in one cycle
  always_comb begin
    full_d = full_q;
    if (full_set) full_d[wbank_q] = 1'b1;
    if (full_clr) full_d[rbank_q] = 1'b0;
    ovf_d = (ovf_q & ~bus.i_clear) | ovf_set;
  end

`ifdef FFTREADER_SYNCCHK_EN
  always_comb serr_d = (serr_q & ~bus.i_clear) | serr_set;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) serr_q <= 1'b0;
    else         serr_q <= serr_d;
  end

  assign bus.o_syncerr = serr_q;
`else
  assign bus.o_syncerr = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wstate_q <= W_HUNT;
      wbank_q  <= 1'b0;
      waddr_q  <= '0;
      full_q   <= '0;
      rstate_q <= R_IDLE;
      rbank_q  <= 1'b0;
      raddr_q  <= '0;
      rdone_q  <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      ovld_q   <= 1'b0;
      odata_q  <= '0;
      oidx_q   <= '0;
      olast_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wbank_q  <= wbank_d;
      waddr_q  <= waddr_d;
      full_q   <= full_d;
      rstate_q <= rstate_d;
      rbank_q  <= rbank_d;
      raddr_q  <= raddr_d;
      rdone_q  <= rdone_d;
      s1_vld_q <= s1_vld_d;
      s1_idx_q <= s1_idx_d;
      ovld_q   <= ovld_d;
      odata_q  <= odata_d;
      oidx_q   <= oidx_d;
      olast_q  <= olast_d;
      ovf_q    <= ovf_d;
    end
  end

  // bank storage is deliberately left out of reset
  always_ff @(posedge i_clk) begin
    if (we)    mem[{wbank_q, we_addr}] <= bus.i_result;
    if (rd_en) rdata_q <= mem[{rbank_q, raddr_q}];
  end

  assign bus.o_valid    = ovld_q;
  assign bus.o_data     = odata_q;
  assign bus.o_index    = oidx_q;
  assign bus.o_last     = olast_q;
  assign bus.o_overflow = ovf_q;
endmodule
